// File: rtl/simd_pkg.sv
// Shared types and constants for the SIMD convolution sequencer:
// Q8.8 constants, the default data width and the sequencer FSM encoding.
package simd_pkg;

  localparam int DW_DEF = 16;

  localparam logic [15:0] Q_ONE = 16'h0100;
  localparam logic [15:0] Q_MAX = 16'h7FFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_MAC,
    S_WAIT,
    S_CAPT,
    S_OUT,
    S_FIN
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/simd_stream_out_reg.sv
// Valid/ready output register: load captures a word and raises valid,
// pop drops valid; data is held stable while valid waits for ready.
module simd_stream_out_reg #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/simd_conv_sequencer.sv
// Sequences a row of SIMD MAC PEs through convolution windows: clear, TAPS MACs, capture, emit.
// Optional SEQ_STALL_CNT_EN adds stall_cnt: saturating count of MAC cycles without a pixel.
module simd_conv_sequencer
  import simd_pkg::*;
#(
  parameter  int LANES = 4,
  parameter  int TAPS  = 9,
  parameter  int DW    = DW_DEF,
  localparam int TW    = $clog2(TAPS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [15:0]         num_win,
  output logic                busy,
  output logic                done,
  input  logic                px_valid,
  output logic                px_ready,
  input  logic [DW-1:0]       px_data,
  output logic [TW-1:0]       w_addr,
  input  logic [LANES*DW-1:0] w_rdata,
  output logic                pe_clr_acc,
  output logic                pe_en_mac,
  output logic [DW-1:0]       pe_pixel,
  output logic [LANES*DW-1:0] pe_weight,
  input  logic [LANES*DW-1:0] pe_result,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [LANES*DW-1:0] res_data
`ifdef SEQ_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  state_t        state, state_nxt;
  logic [15:0]   num_win_q;
  logic [15:0]   win;
  logic [TW-1:0] tap;
  logic          accept;
  logic          fire;
  logic          last_tap;
  logic          res_hs;

  assign accept   = (state == S_IDLE) && start;
  assign fire     = (state == S_MAC) && px_valid;
  assign last_tap = (tap == TW'(TAPS - 1));
  assign res_hs   = (state == S_OUT) && res_valid && res_ready;

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FIN);
  assign px_ready   = (state == S_MAC);
  assign pe_clr_acc = (state == S_CLEAR);
  // Look one tap ahead on a fire so the next cycle's read data already matches the next pixel.
  assign w_addr     = (state == S_MAC) ? tap + TW'(fire) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = (num_win == 16'd0) ? S_FIN : S_CLEAR;
      S_CLEAR: state_nxt = S_MAC;
      S_MAC:   if (fire && last_tap) state_nxt = S_WAIT;
      S_WAIT:  state_nxt = S_CAPT;
      S_CAPT:  state_nxt = S_OUT;
      S_OUT:   if (res_hs) state_nxt = (win + 16'd1 == num_win_q) ? S_FIN : S_CLEAR;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_win_q <= '0;
      win       <= '0;
      tap       <= '0;
    end else begin
      if (accept) begin
        num_win_q <= num_win;
        win       <= '0;
      end else if (res_hs) begin
        win <= win + 16'd1;
      end
      if (state == S_CLEAR) tap <= '0;
      else if (fire)        tap <= tap + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe_en_mac <= 1'b0;
      pe_pixel  <= '0;
      pe_weight <= '0;
    end else begin
      pe_en_mac <= fire;
      if (fire) begin
        pe_pixel  <= px_data;
        pe_weight <= w_rdata;
      end
    end
  end

  // PE outputs have settled one cycle after the final accumulate; capture them in CAPT.
  simd_stream_out_reg #(.W(LANES * DW)) u_out (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == S_CAPT),
    .pop   (res_hs),
    .din   (pe_result),
    .valid (res_valid),
    .data  (res_data)
  );

`ifdef SEQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           stall_cnt <= '0;
    else if (accept)                      stall_cnt <= '0;
    else if (state == S_MAC && !px_valid) stall_cnt <= sat_inc16(stall_cnt);
  end
`endif

endmodule

// File: tb/tb_simd_conv_sequencer.sv
// Bench for simd_conv_sequencer: behavioural PE row and sync weight RAM around the DUT,
// directed scenarios plus randomized jobs checked against a sum-of-products window model.
module tb_simd_conv_sequencer;
  import simd_pkg::*;

  localparam int LANES = 4;
  localparam int TAPS  = 9;
  localparam int DW    = 16;
  localparam int TW    = $clog2(TAPS);
  localparam int LW    = LANES * DW;

  localparam logic [LW-1:0] W1   = {16'h0000, 16'h0080, 16'hFF00, Q_ONE};
  localparam logic [LW-1:0] EXP1 = {16'h0000, 16'h0480, 16'h0000, 16'h0900};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   num_win = '0;
  logic          busy, done;
  logic          px_valid, px_ready;
  logic [DW-1:0] px_data;
  logic [TW-1:0] w_addr;
  logic [LW-1:0] w_rdata = '0;
  logic          pe_clr_acc, pe_en_mac;
  logic [DW-1:0] pe_pixel;
  logic [LW-1:0] pe_weight, pe_result, res_data;
  logic          res_valid, res_ready;
`ifdef SEQ_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  simd_conv_sequencer #(.LANES(LANES), .TAPS(TAPS), .DW(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_win    (num_win),
    .busy       (busy),
    .done       (done),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_data    (px_data),
    .w_addr     (w_addr),
    .w_rdata    (w_rdata),
    .pe_clr_acc (pe_clr_acc),
    .pe_en_mac  (pe_en_mac),
    .pe_pixel   (pe_pixel),
    .pe_weight  (pe_weight),
    .pe_result  (pe_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data)
`ifdef SEQ_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  // Weight RAM: one-cycle read latency, always enabled.
  logic [LW-1:0] wmem [TAPS];
  always @(posedge clk) w_rdata <= (int'(w_addr) < TAPS) ? wmem[w_addr] : '0;

  // PE row: wide accumulator, post-ReLU Q8.8 output saturated at Q_MAX.
  logic signed [47:0] acc [LANES];
  function automatic logic [15:0] pe_out(input logic signed [47:0] a);
    logic signed [47:0] sh;
    sh = a >>> 8;
    if (sh < 0) return 16'h0000;
    if (sh > 48'sd32767) return Q_MAX;
    return sh[15:0];
  endfunction

  always @(posedge clk)
    for (int l = 0; l < LANES; l++)
      if (pe_clr_acc) acc[l] <= '0;
      else if (pe_en_mac)
        acc[l] <= acc[l] + 48'($signed(pe_pixel)) * 48'($signed(pe_weight[l*DW +: DW]));

  always_comb begin
    pe_result = '0;
    for (int l = 0; l < LANES; l++) pe_result[l*DW +: DW] = pe_out(acc[l]);
  end

  // Window model: ReLU(sat(sum(pixel*weight) >> 8)) per lane.
  function automatic logic [LW-1:0] model(input logic [DW-1:0] pix [TAPS]);
    logic [LW-1:0] r;
    longint s;
    r = '0;
    for (int l = 0; l < LANES; l++) begin
      s = 0;
      for (int t = 0; t < TAPS; t++)
        s += longint'($signed(pix[t])) * longint'($signed(wmem[t][l*DW +: DW]));
      s = s >>> 8;
      r[l*DW +: DW] = (s < 0) ? 16'h0000 : (s > longint'(Q_MAX)) ? Q_MAX : s[15:0];
    end
    return r;
  endfunction

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc = 0;
  int n_fire, n_en, n_clr, n_done, n_pxstall, n_stall, n_viol;
  int last_fire_cyc, first_rv_cyc, hs_cyc, done_cyc;
  int px_mode = 0, rr_mode = 0, stall_win = 0, rv_age = 0;
  logic [DW-1:0] px_q [$];
  logic [LW-1:0] got_q [$], exp_q [$];
  logic          fire_s, rv_prev = 1'b0, stalled_prev = 1'b0;
  logic [LW-1:0] prev_data;

  // Monitor at negedge, drive at posedge+1.
  initial begin
    px_valid = 1'b0; px_data = '0; res_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      fire_s = px_valid && px_ready;
      if (fire_s) begin n_fire++; last_fire_cyc = cyc; end
      if (pe_en_mac) n_en++;
      if (pe_clr_acc) n_clr++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (px_ready && !px_valid) n_pxstall++;
      if (res_valid && !rv_prev) first_rv_cyc = cyc;
      if (res_valid && px_ready) n_viol++;
      if (stalled_prev && (!res_valid || res_data !== prev_data)) n_viol++;
      stalled_prev = res_valid && !res_ready;
      prev_data    = res_data;
      if (res_valid && !res_ready) n_stall++;
      if (res_valid && res_ready) begin got_q.push_back(res_data); hs_cyc = cyc; end
      rv_prev = res_valid;
      @(posedge clk); #1;
      if (fire_s && px_q.size() > 0) px_q.delete(0);
      if (px_q.size() == 0) px_valid = 1'b0;
      else case (px_mode)
        0:       px_valid = 1'b1;
        1:       px_valid = !fire_s;
        default: px_valid = 1'($urandom_range(0, 1));
      endcase
      px_data = (px_q.size() > 0) ? px_q[0] : '0;
      case (rr_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default:
          if (res_valid) begin
            res_ready = (rv_age >= ((got_q.size() == stall_win) ? 5 : 0));
            rv_age++;
          end else begin
            res_ready = 1'b0;
            rv_age    = 0;
          end
      endcase
    end
  end

  function automatic logic [15:0] rnd_q(input bit wide);
    return wide ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
  endfunction

  task automatic reset_stats();
    n_fire = 0; n_en = 0; n_clr = 0; n_done = 0; n_pxstall = 0; n_stall = 0; n_viol = 0;
    last_fire_cyc = -100; first_rv_cyc = -100; hs_cyc = -100; done_cyc = -100;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic set_w_t1();
    for (int t = 0; t < TAPS; t++) wmem[t] = W1;
  endtask

  task automatic queue_window(input logic [DW-1:0] pix [TAPS]);
    for (int t = 0; t < TAPS; t++) px_q.push_back(pix[t]);
    exp_q.push_back(model(pix));
  endtask

  task automatic queue_random(input bit wide);
    logic [DW-1:0] pix [TAPS];
    for (int t = 0; t < TAPS; t++) pix[t] = rnd_q(wide);
    queue_window(pix);
  endtask

  task automatic start_job(input logic [15:0] n);
    @(posedge clk); #1;
    num_win = n; start = 1'b1; start_cyc = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (n_done > 0) begin ok = 1'b1; break; end
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, px_ready, pe_clr_acc, pe_en_mac, res_valid} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=000000", {busy, done, px_ready, pe_clr_acc, pe_en_mac, res_valid});
    end
    checks++;
    if ({w_addr, pe_pixel, pe_weight, res_data} !== '0) begin
      failures++; $display("FAIL reset_data w_addr=%h pixel=%h weight=%h res=%h exp=0", w_addr, pe_pixel, pe_weight, res_data);
    end
`ifdef SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_t1(input int mode, input string tag);
    bit ok;
    logic [DW-1:0] pix [TAPS];
    set_w_t1();
    for (int t = 0; t < TAPS; t++) pix[t] = Q_ONE;
    px_mode = mode; rr_mode = 0; reset_stats();
    queue_window(pix);
    start_job(16'd1);
    wait_done(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_done_timeout got=no_done exp=done", tag); end
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL %s_count got=%0d exp=1", tag, got_q.size()); end
    else begin
      checks++;
      if (got_q[0] !== EXP1) begin failures++; $display("FAIL %s_result got=%h exp=%h", tag, got_q[0], EXP1); end
    end
    checks++;
    if (n_en != TAPS || n_clr != 1 || n_done != 1) begin
      failures++; $display("FAIL %s_pulses got en=%0d clr=%0d done=%0d exp en=9 clr=1 done=1", tag, n_en, n_clr, n_done);
    end
  endtask

  task automatic test_single();
    run_t1(0, "t1");
    checks++;
    if (first_rv_cyc - last_fire_cyc != 3) begin
      failures++; $display("FAIL t1_latency got=%0d exp=3", first_rv_cyc - last_fire_cyc);
    end
    checks++;
    if (done_cyc - hs_cyc != 1) begin failures++; $display("FAIL t1_done_delay got=%0d exp=1", done_cyc - hs_cyc); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_toggle();
    run_t1(1, "t2");
    checks++;
    if (n_pxstall != 8) begin failures++; $display("FAIL t2_idle_mac_cycles got=%0d exp=8", n_pxstall); end
`ifdef SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd8) begin failures++; $display("FAIL t2_stall_cnt got=%0d exp=8", stall_cnt); end
`endif
  endtask

  task automatic check_results(input string tag, input int nw);
    checks++;
    if (got_q.size() != nw) begin failures++; $display("FAIL %s_count got=%0d exp=%0d", tag, got_q.size(), nw); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL %s_result[%0d] got=%h exp=%h", tag, i, got_q[i], exp_q[i]); end
    end
    checks++;
    if (n_done != 1 || n_en != nw * TAPS) begin
      failures++; $display("FAIL %s_pulses got done=%0d en=%0d exp done=1 en=%0d", tag, n_done, n_en, nw * TAPS);
    end
  endtask

  task automatic test_stall();
    bit ok;
    for (int t = 0; t < TAPS; t++)
      for (int l = 0; l < LANES; l++) wmem[t][l*DW +: DW] = rnd_q(1'b0);
    px_mode = 0; rr_mode = 2; stall_win = 1; reset_stats();
    for (int w = 0; w < 3; w++) queue_random(1'b0);
    start_job(16'd3);
    wait_done(600, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL t3_done_timeout got=no_done exp=done"); end
    check_results("t3", 3);
    checks++;
    if (n_viol != 0) begin failures++; $display("FAIL t3_stall_hold got=%0d violations exp=0", n_viol); end
    checks++;
    if (n_stall != 5) begin failures++; $display("FAIL t3_stall_cycles got=%0d exp=5", n_stall); end
    checks++;
    if (n_clr != 3) begin failures++; $display("FAIL t3_clr_pulses got=%0d exp=3", n_clr); end
  endtask

  task automatic test_zero();
    bit ok;
    px_mode = 0; rr_mode = 0; reset_stats();
    start_job(16'd0);
    wait_done(20, ok);
    checks++;
    if (!ok || done_cyc - start_cyc < 1 || done_cyc - start_cyc > 2) begin
      failures++; $display("FAIL t4_done_delay got=%0d exp=1..2", done_cyc - start_cyc);
    end
    checks++;
    if (n_clr != 0 || n_en != 0 || n_done != 1 || got_q.size() != 0) begin
      failures++; $display("FAIL t4_activity got clr=%0d en=%0d done=%0d res=%0d exp 0/0/1/0", n_clr, n_en, n_done, got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    logic [DW-1:0] pix [TAPS];
    set_w_t1();
    for (int t = 0; t < TAPS; t++) pix[t] = Q_ONE;
    px_mode = 0; rr_mode = 0; reset_stats();
    queue_window(pix);
    start_job(16'd1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (n_fire >= 4) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL t5_fire_timeout got=%0d fires exp=4", n_fire); end
    @(posedge clk); #2;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, px_ready, w_addr, pe_clr_acc, pe_en_mac, pe_pixel, pe_weight, res_valid, res_data} !== '0) begin
        failures++; $display("FAIL t5_outputs_in_reset got busy=%b px_ready=%b en=%b pixel=%h res_valid=%b exp all 0",
                             busy, px_ready, pe_en_mac, pe_pixel, res_valid);
      end
    end
`ifdef SEQ_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) begin failures++; $display("FAIL t5_stall_cnt_reset got=%0d exp=0", stall_cnt); end
`endif
    px_q.delete();
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_t1(0, "t5_after");
  endtask

  task automatic test_start_busy();
    bit ok, seen;
    for (int t = 0; t < TAPS; t++)
      for (int l = 0; l < LANES; l++) wmem[t][l*DW +: DW] = rnd_q(1'b0);
    px_mode = 0; rr_mode = 0; reset_stats();
    for (int w = 0; w < 2; w++) queue_random(1'b0);
    start_job(16'd2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (px_ready) begin seen = 1'b1; break; end
    end
    @(posedge clk); #1; num_win = 16'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(400, ok);
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (!seen || !ok) begin failures++; $display("FAIL t6_progress got mac=%b done=%b exp 1/1", seen, ok); end
    check_results("t6", 2);
    checks++;
    if (busy !== 1'b0 || n_clr != 2) begin failures++; $display("FAIL t6_extra_job got busy=%b clr=%0d exp 0/2", busy, n_clr); end
  endtask

  task automatic test_random();
    bit ok;
    int nw;
    for (int job = 0; job < 4; job++) begin
      for (int t = 0; t < TAPS; t++)
        for (int l = 0; l < LANES; l++) wmem[t][l*DW +: DW] = rnd_q(job == 0);
      nw = $urandom_range(1, 3);
      px_mode = $urandom_range(0, 2); rr_mode = $urandom_range(0, 2);
      stall_win = $urandom_range(0, nw - 1);
      reset_stats();
      for (int w = 0; w < nw; w++) queue_random(job == 0);
      start_job(16'(nw));
      wait_done(500 * nw, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rnd%0d_done_timeout got=no_done exp=done", job); end
      check_results($sformatf("rnd%0d", job), nw);
`ifdef SEQ_STALL_CNT_EN
      checks++;
      if (int'(stall_cnt) != n_pxstall) begin failures++; $display("FAIL rnd%0d_stall_cnt got=%0d exp=%0d", job, stall_cnt, n_pxstall); end
`endif
    end
  endtask

  initial begin
    reset_stats();
    test_reset();
    test_single();
    test_toggle();
    test_stall();
    test_zero();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
